// File: rtl/dm_pkg.sv
// dm_pkg: shared encodings for the data-memory arbiter and lane control.
// Size codes, FSM states, requester ids and the latched transaction.
package dm_pkg;

  localparam logic [1:0] LEN_BYTE = 2'b00;
  localparam logic [1:0] LEN_HALF = 2'b01;
  localparam logic [1:0] LEN_WORD = 2'b10;
  localparam logic [1:0] LEN_ILL  = 2'b11;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_RESP
  } dm_state_e;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [1:0]  len;
    logic [31:0] wdata;
  } dm_txn_t;

endpackage

// File: rtl/dm_lane_ctl.sv
// dm_lane_ctl: byte-enable, alignment and read-shift decode.
// Purely combinational; also reused by the CPU stage for sign extension.
module dm_lane_ctl
  import dm_pkg::*;
(
  input  logic [1:0] addr_lo,
  input  logic [1:0] len,
  output logic [3:0] be,
  output logic       misalign,
  output logic [4:0] shift
);

  always_comb begin
    be       = 4'b0000;
    misalign = 1'b1;
    unique case (1'b1)
      (len == LEN_BYTE): begin
        be       = 4'b0001 << addr_lo;
        misalign = 1'b0;
      end
      (len == LEN_HALF): begin
        be       = addr_lo[1] ? 4'b1100 : 4'b0011;
        misalign = addr_lo[0];
      end
      (len == LEN_WORD): begin
        be       = 4'b1111;
        misalign = |addr_lo;
      end
      (len == LEN_ILL): begin
        be       = 4'b0000;
        misalign = 1'b1;
      end
    endcase
    if (misalign)
      be = 4'b0000;
  end

  assign shift = {addr_lo, 3'b000};

endmodule

// File: rtl/dm_arbiter.sv
// dm_arbiter: round-robin two-port sequencer for the single-port data memory.
// One transaction at a time: IDLE -> ACCESS -> RESP, or IDLE -> RESP on error.
module dm_arbiter
  import dm_pkg::*;
#(
  parameter int   ADDR_W  = 13,
  parameter logic RR_INIT = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              r0_req,
  input  logic              r0_we,
  input  logic [31:0]       r0_addr,
  input  logic [1:0]        r0_len,
  input  logic [31:0]       r0_wdata,
  output logic              r0_ack,
  output logic [31:0]       r0_rdata,
  output logic              r0_err,
  input  logic              r1_req,
  input  logic              r1_we,
  input  logic [31:0]       r1_addr,
  input  logic [1:0]        r1_len,
  input  logic [31:0]       r1_wdata,
  output logic              r1_ack,
  output logic [31:0]       r1_rdata,
  output logic              r1_err,
  output logic [ADDR_W-3:0] dm_addr,
  output logic [3:0]        dm_be,
  output logic [31:0]       dm_din,
  output logic              dm_we,
  input  logic [31:0]       dm_dout
);

  dm_state_e state_q, state_d;
  dm_txn_t   txn_q, win_txn;
  logic      gnt_q, last_q, err_q;
  logic [31:0] rdata_q;

  logic       any_req, win;
  logic [1:0] lane_addr, lane_len;
  logic [3:0] lane_be;
  logic       lane_mis;
  logic [4:0] lane_shift;
  logic       access, resp;
  logic       unused_addr_hi;

  assign any_req = r0_req | r1_req;
  assign win     = (r0_req & r1_req) ? ~last_q : r1_req;

  always_comb begin
    win_txn.we    = win ? r1_we    : r0_we;
    win_txn.addr  = win ? r1_addr  : r0_addr;
    win_txn.len   = win ? r1_len   : r0_len;
    win_txn.wdata = win ? r1_wdata : r0_wdata;
  end

  // In IDLE the decoder vets the incoming winner; afterwards it serves the latch.
  assign lane_addr = (state_q == S_IDLE) ? win_txn.addr[1:0] : txn_q.addr[1:0];
  assign lane_len  = (state_q == S_IDLE) ? win_txn.len : txn_q.len;

  dm_lane_ctl u_lane (
    .addr_lo  (lane_addr),
    .len      (lane_len),
    .be       (lane_be),
    .misalign (lane_mis),
    .shift    (lane_shift)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (any_req) state_d = lane_mis ? S_RESP : S_ACCESS;
      S_ACCESS: state_d = S_RESP;
      S_RESP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      txn_q   <= '0;
      gnt_q   <= REQ0;
      last_q  <= ~RR_INIT;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && any_req) begin
        txn_q   <= win_txn;
        gnt_q   <= win;
        last_q  <= win;
        err_q   <= lane_mis;
        rdata_q <= '0;
      end
      if (access && !txn_q.we)
        rdata_q <= dm_dout >> lane_shift;
    end
  end

  // Memory controls decode straight from state so reset kills dm_we at once.
  assign access  = (state_q == S_ACCESS);
  assign resp    = (state_q == S_RESP);
  assign dm_we   = access & txn_q.we;
  assign dm_be   = access ? lane_be : 4'b0000;
  assign dm_addr = txn_q.addr[ADDR_W-1:2];
  assign dm_din  = txn_q.wdata;

  assign r0_ack   = resp & (gnt_q == REQ0);
  assign r1_ack   = resp & (gnt_q == REQ1);
  assign r0_rdata = r0_ack ? rdata_q : '0;
  assign r1_rdata = r1_ack ? rdata_q : '0;
  assign r0_err   = r0_ack & err_q;
  assign r1_err   = r1_ack & err_q;

  assign unused_addr_hi = ^txn_q.addr[31:ADDR_W];

endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: scoreboard bench with a negedge-write lane-steering memory.
// Expected acks are queued at drive time and popped when an ack appears.
module tb_dm_arbiter;
  import dm_pkg::*;

  logic        clk, rst_n;
  logic        r0_req, r0_we, r1_req, r1_we;
  logic [31:0] r0_addr, r0_wdata, r1_addr, r1_wdata;
  logic [1:0]  r0_len, r1_len;
  logic        r0_ack, r0_err, r1_ack, r1_err;
  logic [31:0] r0_rdata, r1_rdata;
  logic [10:0] dm_addr;
  logic [3:0]  dm_be;
  logic [31:0] dm_din, dm_dout, wsteer;
  logic        dm_we;

  typedef struct {
    logic        id;
    logic [31:0] rd;
    logic        err;
    logic        chk_rd;
  } exp_t;

  exp_t sb[$];
  int n_chk = 0;
  int n_pass = 0;
  int n_ack0 = 0;
  int n_ack1 = 0;
  logic [31:0] mem [0:2047];

  dm_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_len(r0_len),
    .r0_wdata(r0_wdata), .r0_ack(r0_ack), .r0_rdata(r0_rdata), .r0_err(r0_err),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_len(r1_len),
    .r1_wdata(r1_wdata), .r1_ack(r1_ack), .r1_rdata(r1_rdata), .r1_err(r1_err),
    .dm_addr(dm_addr), .dm_be(dm_be), .dm_din(dm_din), .dm_we(dm_we),
    .dm_dout(dm_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] steer(input logic [31:0] d, input logic [3:0] be);
    if (be[0]) return d;
    else if (be[1]) return d << 8;
    else if (be[2]) return d << 16;
    else return d << 24;
  endfunction

  assign wsteer  = steer(dm_din, dm_be);
  assign dm_dout = mem[dm_addr] & {{8{dm_be[3]}}, {8{dm_be[2]}},
                                   {8{dm_be[1]}}, {8{dm_be[0]}}};

  always @(negedge clk)
    if (dm_we)
      for (int i = 0; i < 4; i++)
        if (dm_be[i]) mem[dm_addr][8*i +: 8] <= wsteer[8*i +: 8];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  task automatic score();
    exp_t e;
    logic id, er;
    logic [31:0] rd;
    id = r1_ack;
    rd = id ? r1_rdata : r0_rdata;
    er = id ? r1_err : r0_err;
    chk("ack_excl", 32'(r0_ack & r1_ack), 0);
    if (sb.size() == 0) chk("spurious_ack", 1, 0);
    else begin
      e = sb.pop_front();
      chk("ack_id", 32'(id), 32'(e.id));
      chk("err", 32'(er), 32'(e.err));
      if (e.chk_rd) chk("rdata", rd, e.rd);
    end
  endtask

  always @(negedge clk) begin
    if (r0_ack) n_ack0 <= n_ack0 + 1;
    if (r1_ack) n_ack1 <= n_ack1 + 1;
    if (r0_ack | r1_ack) score();
  end

  task automatic drive(input logic id, input logic req, input logic we,
                       input logic [31:0] a, input logic [1:0] len,
                       input logic [31:0] wd);
    if (id) begin
      r1_req = req; r1_we = we; r1_addr = a; r1_len = len; r1_wdata = wd;
    end else begin
      r0_req = req; r0_we = we; r0_addr = a; r0_len = len; r0_wdata = wd;
    end
  endtask

  task automatic push(input logic id, input logic [31:0] rd, input logic err,
                      input logic crd);
    exp_t e;
    e.id = id; e.rd = rd; e.err = err; e.chk_rd = crd;
    sb.push_back(e);
  endtask

  task automatic xfer(input logic id, input logic we, input logic [31:0] a,
                      input logic [1:0] len, input logic [31:0] wd,
                      input logic [31:0] rd, input logic err, input logic [3:0] be);
    int cyc;
    logic [3:0] seen_be;
    logic seen_we, touched;
    @(posedge clk);
    @(negedge clk);
    drive(id, 1'b1, we, a, len, wd);
    push(id, rd, err, !we || err);
    cyc = 0; seen_be = 0; seen_we = 0; touched = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
      if (dm_be != 0) seen_be = dm_be;
      seen_we |= dm_we;
      touched |= (dm_be != 0) | dm_we;
    end while (!(id ? r1_ack : r0_ack) && cyc < 10);
    chk("latency", cyc, err ? 1 : 2);
    drive(id, 1'b0, we, a, len, wd);
    if (err) chk("mem_touched", 32'(touched), 0);
    else begin
      chk("dm_be", 32'(seen_be), 32'(be));
      chk("dm_we", 32'(seen_we), 32'(we));
    end
  endtask

  initial begin
    int cnt, a0, a1, cyc;
    for (int i = 0; i < 2048; i++) mem[i] = '0;
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 0, LEN_BYTE, 0);
    drive(1'b1, 1'b0, 1'b0, 0, LEN_BYTE, 0);
    repeat (2) @(negedge clk);
    chk("rst_ack0", 32'(r0_ack), 0);
    chk("rst_ack1", 32'(r1_ack), 0);
    chk("rst_we", 32'(dm_we), 0);
    chk("rst_be", 32'(dm_be), 0);
    chk("rst_addr", 32'(dm_addr), 0);
    chk("rst_din", dm_din, 0);
    chk("rst_rdata", r0_rdata | r1_rdata, 0);
    mem[16] = 32'h1111_1111;
    mem[17] = 32'h2222_2222;
    rst_n = 1'b1;

    // contention: both held high, first pick is requester 0
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 32'h40, LEN_WORD, 0);
    drive(1'b1, 1'b1, 1'b0, 32'h44, LEN_WORD, 0);
    for (int i = 0; i < 6; i++)
      push(i[0], i[0] ? 32'h2222_2222 : 32'h1111_1111, 1'b0, 1'b1);
    cnt = 0; cyc = 0;
    while (cnt < 6 && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
      if (r0_ack | r1_ack) cnt++;
    end
    chk("cont_acks", cnt, 6);
    r0_req = 1'b0;
    r1_req = 1'b0;

    xfer(0, 1, 32'h10, LEN_WORD, 32'hAABB_CCDD, 0, 0, 4'b1111);
    xfer(0, 0, 32'h10, LEN_WORD, 0, 32'hAABB_CCDD, 0, 4'b1111);
    xfer(0, 0, 32'h13, LEN_BYTE, 0, 32'h0000_00AA, 0, 4'b1000);
    xfer(0, 0, 32'h12, LEN_HALF, 0, 32'h0000_AABB, 0, 4'b1100);
    xfer(1, 1, 32'h11, LEN_BYTE, 32'h0000_0011, 0, 0, 4'b0010);
    xfer(1, 0, 32'h10, LEN_WORD, 0, 32'hAABB_11DD, 0, 4'b1111);
    xfer(1, 0, 32'h10, LEN_HALF, 0, 32'h0000_11DD, 0, 4'b0011);
    xfer(0, 0, 32'h11, LEN_BYTE, 0, 32'h0000_0011, 0, 4'b0010);

    xfer(0, 0, 32'h12, LEN_WORD, 0, 0, 1, 0);
    xfer(0, 0, 32'h11, LEN_HALF, 0, 0, 1, 0);
    xfer(1, 0, 32'h10, LEN_ILL, 0, 0, 1, 0);
    xfer(1, 1, 32'h12, LEN_WORD, 32'hFFFF_FFFF, 0, 1, 0);
    xfer(0, 0, 32'h10, LEN_WORD, 0, 32'hAABB_11DD, 0, 4'b1111);

    // reset during ACCESS of a store, before its negedge
    @(posedge clk);
    @(negedge clk);
    a0 = n_ack0;
    drive(1'b0, 1'b1, 1'b1, 32'h20, LEN_WORD, 32'h1234_5678);
    @(posedge clk); #1;
    chk("pre_rst_we", 32'(dm_we), 1);
    rst_n = 1'b0;
    #1;
    chk("rst_we_drop", 32'(dm_we), 0);
    r0_req = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_no_ack", n_ack0 - a0, 0);
    xfer(0, 0, 32'h20, LEN_WORD, 0, 32'h0000_0000, 0, 4'b1111);

    // r1 holds req for one cycle only
    @(posedge clk);
    @(negedge clk);
    a1 = n_ack1;
    drive(1'b1, 1'b1, 1'b1, 32'h30, LEN_BYTE, 32'h0000_005A);
    push(1'b1, 0, 1'b0, 1'b0);
    @(negedge clk);
    r1_req = 1'b0;
    cyc = 0;
    while (!r1_ack && cyc < 10) begin
      @(posedge clk); #1;
      cyc++;
    end
    repeat (3) @(negedge clk);
    chk("drop_ack_once", n_ack1 - a1, 1);
    chk("drop_mem", 32'(mem[12][7:0]), 32'h5A);
    xfer(0, 0, 32'h30, LEN_BYTE, 0, 32'h0000_005A, 0, 4'b0001);

    repeat (2) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
